// File: rtl/obi_pkg.sv
// Shared definitions for the OBI arbiter slice.
//   arb_mode_e : arbitration mode selector (fixed priority / round-robin)
//   idx_width  : width of an index able to address n items, never below 1
package obi_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// Small synchronous FIFO used to remember which master owns each
// in-flight OBI transaction so responses can be routed back in order.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, data_i: write an entry
//   pop_i         : drop the head entry (ignored while empty)
//   head_o        : current head entry, valid while !empty_o
//   count_o       : number of stored entries
//   full_o,empty_o: occupancy flags
module obi_id_fifo
  import obi_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Head is read combinationally: the response must be routed in the
  // same cycle as the slave's rvalid.
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot being written, so a push is allowed when full
  // if it coincides with a pop.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_arbiter.sv
// N-master to 1-slave OBI arbiter.
// The address phase of the selected master is forwarded combinationally to
// the slave. Accepted transactions record their master index in an ID FIFO;
// in-order slave responses pop the FIFO and raise rvalid on that master.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   m_req_i/m_gnt_o        : per-master request / grant
//   m_addr_i, m_we_i, m_be_i, m_wdata_i : flattened master address phase
//   m_rvalid_o, m_rdata_o  : per-master response valid, broadcast read data
//   s_*                    : slave-side OBI port
//   outstanding_o          : number of in-flight transactions
//   err_o                  : sticky flag, response seen with nothing in flight
module obi_arbiter
  import obi_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_MASTERS-1:0]                 m_req_i,
  output logic [N_MASTERS-1:0]                 m_gnt_o,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [N_MASTERS-1:0]                 m_we_i,
  input  logic [N_MASTERS*DATA_WIDTH/8-1:0]    m_be_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
  output logic [N_MASTERS-1:0]                 m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                m_rdata_o,
  output logic                                 s_req_o,
  input  logic                                 s_gnt_i,
  output logic [ADDR_WIDTH-1:0]                s_addr_o,
  output logic                                 s_we_o,
  output logic [DATA_WIDTH/8-1:0]              s_be_o,
  output logic [DATA_WIDTH-1:0]                s_wdata_o,
  input  logic                                 s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int IDX_W = idx_width(N_MASTERS);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam bit RR_EN = (ARB_MODE == int'(ARB_RR));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_MASTERS);

  // Per-master views of the flattened buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [N_MASTERS];
  logic [BE_W-1:0]       be_arr    [N_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [N_MASTERS];

  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign be_arr[gi]    = m_be_i[gi*BE_W +: BE_W];
      assign wdata_arr[gi] = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic             lock_q, lock_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] winner, sel, head_idx;
  logic [IDX_W:0]   cand;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             accept, rsp_ok;

  // Winner among current requesters, used only while no stall is pending.
  always_comb begin
    winner = '0;
    cand   = '0;
    if (RR_EN) begin
      // Scan downwards so the first requester at/after rr_ptr wins last.
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (cand >= N_EXT) begin
          cand = cand - N_EXT;
        end
        if (m_req_i[cand[IDX_W-1:0]]) begin
          winner = cand[IDX_W-1:0];
        end
      end
    end else begin
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        if (m_req_i[k]) begin
          winner = IDX_W'(k);
        end
      end
    end
  end

  // A stalled request keeps its master selected so the address phase
  // stays stable until the slave grants it.
  assign sel = lock_q ? sel_q : winner;

  // Full is judged on the registered count; a same-cycle pop does not
  // reopen the slave port.
  assign s_req_o   = !fifo_full && m_req_i[sel];
  assign s_addr_o  = addr_arr[sel];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = be_arr[sel];
  assign s_wdata_o = wdata_arr[sel];

  assign accept    = s_req_o && s_gnt_i;
  assign rsp_ok    = s_rvalid_i && !fifo_empty;
  assign m_rdata_o = s_rdata_i;
  assign outstanding_o = fifo_count;
  assign err_o     = err_q;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (accept) begin
      m_gnt_o[sel] = 1'b1;
    end
    if (rsp_ok) begin
      m_rvalid_o[head_idx] = 1'b1;
    end
  end

  always_comb begin
    lock_d   = s_req_o && !s_gnt_i;
    sel_d    = sel;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q || (s_rvalid_i && fifo_empty);
    if (RR_EN && accept) begin
      rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q   <= 1'b0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  obi_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (s_rvalid_i),
    .head_o  (head_idx),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_obi_arbiter.sv
// Testbench for obi_arbiter: instance 0 is fixed priority with 2 masters,
// instance 1 is round-robin with 3 masters; both allow 2 outstanding.
module tb_obi_arbiter;

  localparam int MO = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  // Index [d] selects the instance; instance 0 uses only 2 master slots.
  logic [1:0][2:0]  req_a;
  logic [1:0][95:0] addr_a;
  logic [1:0][2:0]  we_a;
  logic [1:0][11:0] be_a;
  logic [1:0][95:0] wdata_a;
  logic [1:0]       sgnt_a;
  logic [1:0]       srv_a;
  logic [1:0][31:0] srdata_a;

  wire [1:0][2:0]  gnt_w;
  wire [1:0][2:0]  mrv_w;
  wire [1:0][31:0] rdata_w;
  wire [1:0]       sreq_w;
  wire [1:0][31:0] saddr_w;
  wire [1:0]       swe_w;
  wire [1:0][3:0]  sbe_w;
  wire [1:0][31:0] swdata_w;
  wire [1:0][1:0]  outs_w;
  wire [1:0]       err_w;

  assign gnt_w[0][2] = 1'b0;
  assign mrv_w[0][2] = 1'b0;

  obi_arbiter #(.N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                .MAX_OUTSTANDING(MO), .ARB_MODE(0)) dut_fix (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(req_a[0][1:0]), .m_gnt_o(gnt_w[0][1:0]),
    .m_addr_i(addr_a[0][63:0]), .m_we_i(we_a[0][1:0]),
    .m_be_i(be_a[0][7:0]), .m_wdata_i(wdata_a[0][63:0]),
    .m_rvalid_o(mrv_w[0][1:0]), .m_rdata_o(rdata_w[0]),
    .s_req_o(sreq_w[0]), .s_gnt_i(sgnt_a[0]), .s_addr_o(saddr_w[0]),
    .s_we_o(swe_w[0]), .s_be_o(sbe_w[0]), .s_wdata_o(swdata_w[0]),
    .s_rvalid_i(srv_a[0]), .s_rdata_i(srdata_a[0]),
    .outstanding_o(outs_w[0]), .err_o(err_w[0])
  );

  obi_arbiter #(.N_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                .MAX_OUTSTANDING(MO), .ARB_MODE(1)) dut_rr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(req_a[1]), .m_gnt_o(gnt_w[1]),
    .m_addr_i(addr_a[1]), .m_we_i(we_a[1]),
    .m_be_i(be_a[1]), .m_wdata_i(wdata_a[1]),
    .m_rvalid_o(mrv_w[1]), .m_rdata_o(rdata_w[1]),
    .s_req_o(sreq_w[1]), .s_gnt_i(sgnt_a[1]), .s_addr_o(saddr_w[1]),
    .s_we_o(swe_w[1]), .s_be_o(sbe_w[1]), .s_wdata_o(swdata_w[1]),
    .s_rvalid_i(srv_a[1]), .s_rdata_i(srdata_a[1]),
    .outstanding_o(outs_w[1]), .err_o(err_w[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int d, input logic [2:0] req, input logic gnt,
                       input logic rv, input logic [31:0] rd);
    req_a[d]    = req;
    sgnt_a[d]   = gnt;
    srv_a[d]    = rv;
    srdata_a[d] = rd;
  endtask

  // One cycle of a trace: inputs plus the outputs expected in that cycle.
  typedef struct {
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        sreq;
    logic [2:0]  mgnt;
    logic [2:0]  mrv;
    logic [1:0]  outs;
    int          selm;
  } vec_t;

  vec_t vf[6];
  vec_t vr[8];

  task automatic apply_vec(input int d, input vec_t v, input string tag);
    drive(d, v.req, v.gnt, v.rv, v.rdata);
    @(negedge clk_i);
    $display("%s: req=%b gnt=%b rvalid=%b -> s_req=%b m_gnt=%b m_rvalid=%b outstanding=%0d",
             tag, v.req, v.gnt, v.rv, sreq_w[d], gnt_w[d], mrv_w[d], outs_w[d]);
    check({tag, "_sreq"}, 64'(sreq_w[d]), 64'(v.sreq));
    check({tag, "_mgnt"}, 64'(gnt_w[d]), 64'(v.mgnt));
    check({tag, "_mrvalid"}, 64'(mrv_w[d]), 64'(v.mrv));
    check({tag, "_outstanding"}, 64'(outs_w[d]), 64'(v.outs));
    check({tag, "_rdata"}, 64'(rdata_w[d]), 64'(v.rdata));
    if (v.sreq) begin
      check({tag, "_saddr"}, 64'(saddr_w[d]), 64'(addr_a[d][v.selm*32 +: 32]));
    end
    tick();
  endtask

  int          exp_out_b[8]  = '{0, 1, 2, 2, 2, 1, 1, 2};
  logic        exp_sreq_b[8] = '{1, 1, 0, 0, 0, 1, 1, 0};

  // Reference model: a queue of owning master ids, a held selection while
  // stalled, and a round-robin start index.
  task automatic rand_run(input int d, input int ncyc);
    int         q[$];
    int         held;
    int         rr;
    int         nm;
    int         sel;
    int         k;
    bit         found;
    logic       err_m;
    logic       exp_sreq;
    logic [2:0] req, gprev, exp_g, exp_r;
    logic       gnt, rv;
    logic [31:0] rd;
    held = -1; rr = 0; err_m = 1'b0;
    nm = (d == 0) ? 2 : 3;
    req = '0; gprev = '0;
    for (int c = 0; c < ncyc; c++) begin
      for (int m = 0; m < nm; m++) begin
        // A master with an ungranted request keeps it (and its payload).
        if (!(req[m] && !gprev[m])) begin
          req[m] = ($urandom_range(0, 1) == 1);
          addr_a[d][m*32 +: 32]  = $urandom;
          we_a[d][m]             = ($urandom_range(0, 1) == 1);
          be_a[d][m*4 +: 4]      = 4'($urandom_range(0, 15));
          wdata_a[d][m*32 +: 32] = $urandom;
        end
      end
      gnt = ($urandom_range(0, 3) != 0);
      rv  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      rd  = $urandom;
      drive(d, req, gnt, rv, rd);

      sel = 0;
      if (held >= 0) begin
        sel = held;
      end else begin
        found = 1'b0;
        for (int o = 0; o < nm; o++) begin
          k = (d == 1) ? (rr + o) % nm : o;
          if (!found && req[k]) begin
            sel = k;
            found = 1'b1;
          end
        end
      end
      exp_sreq = (q.size() < MO) && (req != 3'b000);
      exp_g = (exp_sreq && gnt) ? (3'b001 << sel) : 3'b000;
      exp_r = (rv && q.size() > 0) ? (3'b001 << q[0]) : 3'b000;

      @(negedge clk_i);
      check("rand_sreq", 64'(sreq_w[d]), 64'(exp_sreq));
      check("rand_mgnt", 64'(gnt_w[d]), 64'(exp_g));
      check("rand_mrvalid", 64'(mrv_w[d]), 64'(exp_r));
      check("rand_outstanding", 64'(outs_w[d]), 64'(q.size()));
      check("rand_err", 64'(err_w[d]), 64'(err_m));
      check("rand_rdata", 64'(rdata_w[d]), 64'(rd));
      if (exp_sreq) begin
        check("rand_saddr", 64'(saddr_w[d]), 64'(addr_a[d][sel*32 +: 32]));
        check("rand_swe", 64'(swe_w[d]), 64'(we_a[d][sel]));
        check("rand_sbe", 64'(sbe_w[d]), 64'(be_a[d][sel*4 +: 4]));
        check("rand_swdata", 64'(swdata_w[d]), 64'(wdata_a[d][sel*32 +: 32]));
      end
      if (exp_r != 3'b000) begin
        $display("rand d%0d: response to master %0d rdata=0x%08h", d, q[0], rd);
      end
      if (rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (exp_sreq && gnt) begin
        $display("rand d%0d: accept master %0d addr=0x%08h", d, sel, addr_a[d][sel*32 +: 32]);
        q.push_back(sel);
        rr = (sel + 1) % nm;
        held = -1;
      end else if (exp_sreq) begin
        held = sel;
      end else begin
        held = -1;
      end
      gprev = exp_g;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    req_a = '0; we_a = '0; be_a = '0; wdata_a = '0;
    sgnt_a = '0; srv_a = '0; srdata_a = '0;
    addr_a[0] = {32'h0, 32'h2000_0004, 32'h1000_0000};
    addr_a[1] = {32'h3000_0008, 32'h2000_0004, 32'h1000_0000};

    // Reset values on both instances.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      check("reset_mgnt", 64'(gnt_w[d]), 64'd0);
      check("reset_mrvalid", 64'(mrv_w[d]), 64'd0);
      check("reset_sreq", 64'(sreq_w[d]), 64'd0);
      check("reset_outstanding", 64'(outs_w[d]), 64'd0);
      check("reset_err", 64'(err_w[d]), 64'd0);
    end
    tick();
    rst_ni = 1'b1;

    // Fixed priority, both requesting, 1-cycle response latency.
    vf[0] = '{3'b011, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 3'b001, 3'b000, 2'd0, 0};
    vf[1] = '{3'b011, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 3'b001, 3'b001, 2'd1, 0};
    vf[2] = '{3'b011, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 3'b001, 3'b001, 2'd1, 0};
    vf[3] = '{3'b011, 1'b1, 1'b1, 32'h3333_3333, 1'b1, 3'b001, 3'b001, 2'd1, 0};
    vf[4] = '{3'b000, 1'b1, 1'b1, 32'h4444_4444, 1'b0, 3'b000, 3'b001, 2'd1, 0};
    vf[5] = '{3'b000, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 3'b000, 3'b000, 2'd0, 0};
    for (int i = 0; i < 6; i++) apply_vec(0, vf[i], "fixed_vec");

    // Round-robin, three requesters, grant order 0,1,2,0,1,2.
    vr[0] = '{3'b111, 1'b1, 1'b0, 32'hA000_0000, 1'b1, 3'b001, 3'b000, 2'd0, 0};
    vr[1] = '{3'b111, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 3'b010, 3'b001, 2'd1, 1};
    vr[2] = '{3'b111, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 3'b100, 3'b010, 2'd1, 2};
    vr[3] = '{3'b111, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 3'b001, 3'b100, 2'd1, 0};
    vr[4] = '{3'b111, 1'b1, 1'b1, 32'hA000_0004, 1'b1, 3'b010, 3'b001, 2'd1, 1};
    vr[5] = '{3'b111, 1'b1, 1'b1, 32'hA000_0005, 1'b1, 3'b100, 3'b010, 2'd1, 2};
    vr[6] = '{3'b000, 1'b0, 1'b1, 32'hA000_0006, 1'b0, 3'b000, 3'b100, 2'd1, 0};
    vr[7] = '{3'b000, 1'b0, 1'b0, 32'hA000_0007, 1'b0, 3'b000, 3'b000, 2'd0, 0};
    for (int i = 0; i < 8; i++) apply_vec(1, vr[i], "rr_vec");

    // Stall with master 1 selected; master 0 arrives mid-stall.
    we_a[0] = 3'b010; be_a[0] = 12'h0_3F; wdata_a[0] = {32'h0, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    for (int c = 0; c < 3; c++) begin
      drive(0, (c == 2) ? 3'b011 : 3'b010, 1'b0, 1'b0, 32'h0);
      @(negedge clk_i);
      check("stall_saddr", 64'(saddr_w[0]), 64'h2000_0004);
      check("stall_mgnt", 64'(gnt_w[0]), 64'd0);
      tick();
    end
    drive(0, 3'b011, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    $display("stall: master 1 granted addr=0x%08h", saddr_w[0]);
    check("stall_gnt_m1", 64'(gnt_w[0]), 64'b010);
    check("stall_addr_m1", 64'(saddr_w[0]), 64'h2000_0004);
    check("stall_we_m1", 64'(swe_w[0]), 64'd1);
    check("stall_be_m1", 64'(sbe_w[0]), 64'h3);
    check("stall_wdata_m1", 64'(swdata_w[0]), 64'hD1D1_D1D1);
    tick();
    drive(0, 3'b001, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    $display("stall: master 0 granted addr=0x%08h", saddr_w[0]);
    check("stall_gnt_m0", 64'(gnt_w[0]), 64'b001);
    check("stall_addr_m0", 64'(saddr_w[0]), 64'h1000_0000);
    check("stall_be_m0", 64'(sbe_w[0]), 64'hF);
    check("stall_outs1", 64'(outs_w[0]), 64'd1);
    tick();
    // In-order routing of the two responses.
    drive(0, 3'b000, 1'b0, 1'b1, 32'hAAAA_5555);
    @(negedge clk_i);
    $display("order: m_rvalid=%b rdata=0x%08h", mrv_w[0], rdata_w[0]);
    check("order_first_rvalid", 64'(mrv_w[0]), 64'b010);
    check("order_first_rdata", 64'(rdata_w[0]), 64'hAAAA_5555);
    check("order_outs2", 64'(outs_w[0]), 64'd2);
    tick();
    drive(0, 3'b000, 1'b0, 1'b1, 32'h1234_5678);
    @(negedge clk_i);
    $display("order: m_rvalid=%b rdata=0x%08h", mrv_w[0], rdata_w[0]);
    check("order_second_rvalid", 64'(mrv_w[0]), 64'b001);
    check("order_second_rdata", 64'(rdata_w[0]), 64'h1234_5678);
    tick();
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("order_drained", 64'(outs_w[0]), 64'd0);
    tick();

    // Outstanding limit: immediate grants, responses 4 cycles later.
    for (int c = 0; c < 8; c++) begin
      drive(0, 3'b001, 1'b1, (c == 4 || c == 5), 32'hB000_0000 + 32'(c));
      @(negedge clk_i);
      $display("limit c%0d: s_req=%b outstanding=%0d", c, sreq_w[0], outs_w[0]);
      check("limit_outs", 64'(outs_w[0]), 64'(exp_out_b[c]));
      check("limit_sreq", 64'(sreq_w[0]), 64'(exp_sreq_b[c]));
      check("limit_mgnt", 64'(gnt_w[0]), 64'(exp_sreq_b[c]));
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 3'b000, 1'b0, 1'b1, 32'hC000_0000);
      @(negedge clk_i);
      check("limit_drain_rvalid", 64'(mrv_w[0]), 64'b001);
      tick();
    end
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("limit_drained", 64'(outs_w[0]), 64'd0);
    tick();

    // Spurious response, then reset with one transaction in flight.
    drive(0, 3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("spurious_no_rvalid", 64'(mrv_w[0]), 64'd0);
    check("spurious_err_before", 64'(err_w[0]), 64'd0);
    tick();
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    $display("spurious: err=%b", err_w[0]);
    check("spurious_err_set", 64'(err_w[0]), 64'd1);
    check("spurious_fifo_unchanged", 64'(outs_w[0]), 64'd0);
    tick();
    drive(0, 3'b001, 1'b1, 1'b0, 32'h0);
    tick();
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("inflight_outs", 64'(outs_w[0]), 64'd1);
    check("err_sticky", 64'(err_w[0]), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    $display("async reset: outstanding=%0d err=%b", outs_w[0], err_w[0]);
    check("async_rst_outs", 64'(outs_w[0]), 64'd0);
    check("async_rst_err", 64'(err_w[0]), 64'd0);
    check("async_rst_sreq", 64'(sreq_w[0]), 64'd0);
    tick();
    rst_ni = 1'b1;
    drive(0, 3'b000, 1'b0, 1'b1, 32'h0BAD_0BAD);
    @(negedge clk_i);
    check("late_rsp_no_rvalid", 64'(mrv_w[0]), 64'd0);
    tick();
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("late_rsp_err", 64'(err_w[0]), 64'd1);
    tick();

    // Randomised traffic against the reference model, fresh reset first.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    rand_run(0, 200);
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0);
    rand_run(1, 200);
    drive(1, 3'b000, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
